// File: rtl/logicnet_pkg.sv
// Shared types and constants for the LogicNet input front-end.
// The threshold reset helper returns 64 bits; callers truncate to their feature width.
package logicnet_pkg;
  typedef enum logic [1:0] {COLLECT = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_e;

  localparam int QBITS   = 2;
  localparam int NUM_THR = 3;

  // Default thresholds sit at 1/4, 2/4 and 3/4 of full scale.
  function automatic logic [63:0] thr_rst_val(input int feat_w, input int j);
    return 64'(j + 1) << (feat_w - 2);
  endfunction
endpackage

// File: rtl/feature_quantizer.sv
// Combinational 2-bit quantizer: counts how many thresholds the word meets or exceeds.
// The count does not depend on the order of the thresholds.
module feature_quantizer
  import logicnet_pkg::*;
#(
  parameter int FEAT_W = 16
) (
  input  logic [FEAT_W-1:0]              data,
  input  logic [NUM_THR-1:0][FEAT_W-1:0] thr,
  output logic [QBITS-1:0]               code
);
  always_comb begin
    code = '0;
    for (int j = 0; j < NUM_THR; j++)
      if (data >= thr[j]) code = code + QBITS'(1);
  end
endmodule

// File: rtl/logicnet_input_quantizer.sv
// Quantizes a stream of raw features into 2-bit codes and packs each sample into
// a layer-0 vector; the assembly register plus the output register form a double buffer.
module logicnet_input_quantizer
  import logicnet_pkg::*;
#(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W       = 16,
  parameter int THR_IDX_W    = $clog2(3*NUM_FEATURES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      thr_wr_en,
  input  logic [THR_IDX_W-1:0]      thr_wr_idx,
  input  logic [FEAT_W-1:0]         thr_wr_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FEAT_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*NUM_FEATURES-1:0] out_vec,
  output logic                      err_len
);
  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int VEC_W = QBITS*NUM_FEATURES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES-1);

  logic [NUM_FEATURES-1:0][NUM_THR-1:0][FEAT_W-1:0] thr_q, thr_d;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VEC_W-1:0]  asm_q, asm_d, asm_new;
  logic [VEC_W-1:0]  out_vec_q, out_vec_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic [QBITS-1:0]  code;
  logic              acc, out_free;

  feature_quantizer #(.FEAT_W(FEAT_W)) u_quant (
    .data (in_data),
    .thr  (thr_q[idx_q]),
    .code (code)
  );

  // Out-of-range indices match no slot and are therefore ignored.
  always_comb begin
    thr_d = thr_q;
    if (thr_wr_en)
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int j = 0; j < NUM_THR; j++)
          if (thr_wr_idx == THR_IDX_W'(NUM_THR*f + j)) thr_d[f][j] = thr_wr_data;
  end

  always_comb begin
    asm_new = asm_q;
    for (int i = 0; i < NUM_FEATURES; i++)
      if (idx_q == IDX_W'(i)) asm_new[i*QBITS +: QBITS] = code;
  end

  assign in_ready = (state_q != HOLD);
  assign acc      = in_valid && in_ready;
  // Output register can take a new vector if empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = 1'b0;
    case (state_q)
      COLLECT: if (acc) begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (!in_last) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else if (out_free) begin
            out_vec_d   = asm_new;
            out_valid_d = 1'b1;
          end else begin
            asm_d   = asm_new;
            state_d = HOLD;
          end
        end else if (in_last) begin
          err_d = 1'b1;
          idx_d = '0;
        end else begin
          asm_d = asm_new;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      HOLD: if (out_free) begin
        out_vec_d   = asm_q;
        out_valid_d = 1'b1;
        state_d     = COLLECT;
      end
      DRAIN: if (acc && in_last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      asm_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int j = 0; j < NUM_THR; j++)
          thr_q[f][j] <= FEAT_W'(thr_rst_val(FEAT_W, j));
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      thr_q       <= thr_d;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_valid = out_valid_q;
  assign err_len   = err_q;
endmodule
